// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (FETCH, HALT, ERROR)
//   NOP_WORD      : bubble word (addi x0,x0,0) placed in IF/ID when invalid
//   SELF_LOOP_WORD: beq x0,x0,0, the end-of-program marker
//   if_id_t       : IF/ID pipeline register contents {pc, instruction, valid}
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HALT  = 2'd1,
    ERROR = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD       = 32'h00000013;
  localparam logic [31:0] SELF_LOOP_WORD = 32'h00000063;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instruction;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset (loads a bubble)
//   hold      : keep the current contents
//   bubble    : replace the contents with an invalid NOP entry (wins over hold)
//   load      : capture load_data (ignored while hold)
//   load_data : new {pc, instruction, valid} entry
//   q         : registered contents
module if_id_register
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] BUBBLE_WORD = NOP_WORD
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   bubble,
  input  logic   load,
  input  if_id_t load_data,
  output if_id_t q
);

  localparam if_id_t BUBBLE_ENTRY = '{pc: 64'd0, instruction: BUBBLE_WORD, valid: 1'b0};

  if_id_t q_reg;

  // Bubble has priority so a stall that coincides with a flush still
  // invalidates the stage; with no control asserted the contents hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= BUBBLE_ENTRY;
    end else if (bubble) begin
      q_reg <= BUBBLE_ENTRY;
    end else if (load && !hold) begin
      q_reg <= load_data;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory
// address, captures the returned word into IF/ID, and applies stall, flush
// and branch redirect. Stops on a self-loop (HALT) or on an illegal fetch
// address (ERROR, sticky until reset).
// Ports:
//   clk, reset        : clock and asynchronous active-low reset
//   stall, flush      : hazard controls from ID
//   branch_taken/target: redirect request from EX
//   Inst_Address      : current PC to instruction memory (combinational)
//   Instruction       : word read for Inst_Address in the same cycle
//   if_id_pc/instruction/valid : IF/ID register outputs
//   halted, fetch_error: status flags
//   fetch_count       : saturating count of valid IF/ID deliveries
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned IMEM_BYTES = 208,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fetch_error,
  output logic [31:0] fetch_count
);
  import rv_fetch_pkg::*;

  localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES) - 64'd4;

  fetch_state_t state_reg;
  logic [63:0]  pc_reg;
  logic         halted_reg;
  logic         fetch_error_reg;
  logic [31:0]  count_reg;

  logic [63:0]  pc_plus4;
  logic         pc_at_end;
  logic         target_legal;
  logic         ifr_hold;
  logic         ifr_bubble;
  logic         ifr_load;
  if_id_t       ifr_data;
  if_id_t       ifr_q;

  assign pc_plus4     = pc_reg + 64'd4;
  // The PC only ever holds legal addresses, so this check fires before
  // pc+4 could leave the memory and the add never wraps.
  assign pc_at_end    = (pc_plus4 > LAST_PC);
  assign target_legal = (branch_target[1:0] == 2'b00) && (branch_target <= LAST_PC);

  // IF/ID control decode, mirroring the update priority of the FSM below.
  always_comb begin
    ifr_hold   = 1'b0;
    ifr_bubble = 1'b0;
    ifr_load   = 1'b0;
    case (state_reg)
      FETCH: begin
        if (branch_taken) begin
          ifr_bubble = 1'b1;
        end else if (stall) begin
          ifr_hold   = !flush;
          ifr_bubble = flush;
        end else if (flush) begin
          ifr_bubble = 1'b1;
        end else begin
          ifr_load = 1'b1;
        end
      end
      HALT: begin
        if (stall && !flush && !branch_taken) begin
          ifr_hold = 1'b1;
        end else begin
          ifr_bubble = 1'b1;
        end
      end
      default: ifr_bubble = 1'b1;
    endcase
  end

  assign ifr_data = '{pc: pc_reg, instruction: Instruction, valid: 1'b1};

  if_id_register #(
    .BUBBLE_WORD(NOP_WORD)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .hold     (ifr_hold),
    .bubble   (ifr_bubble),
    .load     (ifr_load),
    .load_data(ifr_data),
    .q        (ifr_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_PC;
      halted_reg      <= 1'b0;
      fetch_error_reg <= 1'b0;
      count_reg       <= 32'd0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (branch_taken) begin
            if (target_legal) begin
              pc_reg <= branch_target;
            end else begin
              state_reg       <= ERROR;
              fetch_error_reg <= 1'b1;
            end
          end else if (stall) begin
            pc_reg <= pc_reg;
          end else if (flush) begin
            if (pc_at_end) begin
              state_reg       <= ERROR;
              fetch_error_reg <= 1'b1;
            end else begin
              pc_reg <= pc_plus4;
            end
          end else begin
            if (count_reg != 32'hFFFF_FFFF) begin
              count_reg <= count_reg + 32'd1;
            end
            // The self-loop word is delivered once, then fetch parks on it;
            // this takes precedence over the end-of-memory check.
            if (Instruction == SELF_LOOP_WORD) begin
              state_reg  <= HALT;
              halted_reg <= 1'b1;
            end else if (pc_at_end) begin
              state_reg       <= ERROR;
              fetch_error_reg <= 1'b1;
            end else begin
              pc_reg <= pc_plus4;
            end
          end
        end
        HALT: begin
          if (branch_taken) begin
            halted_reg <= 1'b0;
            if (target_legal) begin
              pc_reg    <= branch_target;
              state_reg <= FETCH;
            end else begin
              state_reg       <= ERROR;
              fetch_error_reg <= 1'b1;
            end
          end
        end
        ERROR: begin
          fetch_error_reg <= 1'b1;
        end
        default: begin
          state_reg       <= ERROR;
          fetch_error_reg <= 1'b1;
        end
      endcase
    end
  end

  assign Inst_Address      = pc_reg;
  assign if_id_pc          = ifr_q.pc;
  assign if_id_instruction = ifr_q.instruction;
  assign if_id_valid       = ifr_q.valid;
  assign halted            = halted_reg;
  assign fetch_error       = fetch_error_reg;
  assign fetch_count       = count_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit with a 208-byte program image.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'd0;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        halted;
  logic        fetch_error;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] exp_count  = 32'd0;
  logic [31:0] last_count = 32'd0;

  always #5 clk = ~clk;

  // Program image: a few hand-placed words, self-loop at 204, and
  // addi x0,x0,idx filler everywhere else.
  function automatic logic [31:0] img(input logic [63:0] a);
    int idx;
    if (a >= 64'd208) return 32'h0;
    idx = int'(a[7:2]);
    case (idx)
      0:       return 32'h00000513;
      2:       return 32'h00A2B023;
      22:      return 32'h00000293;
      51:      return 32'h00000063;
      default: return 32'h00000013 | (32'(idx) << 20);
    endcase
  endfunction

  assign Instruction = img(Inst_Address);

  instruction_fetch_unit #(
    .RESET_PC  (64'd0),
    .IMEM_BYTES(208),
    .NOP_WORD  (32'h00000013)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .Inst_Address     (Inst_Address),
    .Instruction      (Instruction),
    .if_id_pc         (if_id_pc),
    .if_id_instruction(if_id_instruction),
    .if_id_valid      (if_id_valid),
    .halted           (halted),
    .fetch_error      (fetch_error),
    .fetch_count      (fetch_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Drive one cycle of inputs; a normal fetch pushes its expected delivery.
  task automatic issue(input logic s, input logic f, input logic b,
                       input logic [63:0] t, input logic push, input logic [63:0] epc);
    exp_t e;
    stall = s;
    flush = f;
    branch_taken = b;
    branch_target = t;
    if (push) begin
      e.pc = epc;
      e.instr = img(epc);
      sb.push_back(e);
      exp_count++;
    end
    @(negedge clk);
    stall = 1'b0;
    flush = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic run(input logic [63:0] p);
    issue(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, p);
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
  endtask

  // Monitor: every step of fetch_count marks a new IF/ID delivery.
  always @(negedge clk) begin
    if (reset === 1'b1 && fetch_count !== last_count) begin
      chk("count_step", 64'(fetch_count), 64'(last_count + 32'd1));
      chk("deliver_valid", 64'(if_id_valid), 64'd1);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_delivery: got pc %0h instr %0h expected none", if_id_pc, if_id_instruction);
      end else begin
        mon_e = sb.pop_front();
        chk("deliver_pc", if_id_pc, mon_e.pc);
        chk("deliver_instr", 64'(if_id_instruction), 64'(mon_e.instr));
      end
    end
    last_count = fetch_count;
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_addr"},  Inst_Address, 64'd0);
    chk({tag, "_pc"},    if_id_pc, 64'd0);
    chk({tag, "_instr"}, 64'(if_id_instruction), 64'h13);
    chk({tag, "_valid"}, 64'(if_id_valid), 64'd0);
    chk({tag, "_halt"},  64'(halted), 64'd0);
    chk({tag, "_err"},   64'(fetch_error), 64'd0);
    chk({tag, "_count"}, 64'(fetch_count), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    reset = 1'b1;
    chk("c1_addr", Inst_Address, 64'd0);
    run(64'd0);
    chk("c1_next_addr", Inst_Address, 64'd4);
    chk("c1_valid", 64'(if_id_valid), 64'd1);
    chk("c1_instr", 64'(if_id_instruction), 64'h00000513);
    run(64'd4);

    // Stall three cycles at pc = 8.
    for (int k = 0; k < 3; k++) begin
      issue(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
      chk("stall_addr", Inst_Address, 64'd8);
      chk("stall_pc", if_id_pc, 64'd4);
      chk("stall_count", 64'(fetch_count), 64'(exp_count));
    end
    run(64'd8);
    chk("post_stall_instr", 64'(if_id_instruction), 64'h00A2B023);
    run(64'd12);

    // Redirect overrides stall.
    issue(1'b1, 1'b0, 1'b1, 64'h58, 1'b0, 64'd0);
    chk("br_addr", Inst_Address, 64'h58);
    chk("br_valid", 64'(if_id_valid), 64'd0);
    chk("br_count", 64'(fetch_count), 64'(exp_count));
    run(64'h58);
    chk("br_target_instr", 64'(if_id_instruction), 64'h00000293);
    chk("br_next_addr", Inst_Address, 64'h5C);

    // Flush alone advances pc; stall+flush holds pc.
    issue(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0);
    chk("flush_addr", Inst_Address, 64'h60);
    chk("flush_valid", 64'(if_id_valid), 64'd0);
    run(64'h60);
    issue(1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0);
    chk("stflush_addr", Inst_Address, 64'h64);
    chk("stflush_valid", 64'(if_id_valid), 64'd0);

    // Run to the self-loop at 204.
    for (longint unsigned p = 64'h64; p <= 64'd204; p += 4) run(p);
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_addr", Inst_Address, 64'd204);
    chk("halt_instr", 64'(if_id_instruction), 64'h00000063);
    for (int k = 0; k < 2; k++) begin
      idle();
      chk("halted_valid", 64'(if_id_valid), 64'd0);
      chk("halted_addr", Inst_Address, 64'd204);
      chk("halted_count", 64'(fetch_count), 64'(exp_count));
      chk("halted_flag", 64'(halted), 64'd1);
    end

    // Legal redirect leaves HALT.
    issue(1'b0, 1'b0, 1'b1, 64'h10, 1'b0, 64'd0);
    chk("unhalt_flag", 64'(halted), 64'd0);
    chk("unhalt_addr", Inst_Address, 64'h10);
    chk("unhalt_valid", 64'(if_id_valid), 64'd0);
    run(64'h10);
    chk("unhalt_next_addr", Inst_Address, 64'h14);

    // Misaligned target goes to ERROR, which only reset clears.
    issue(1'b0, 1'b0, 1'b1, 64'h6A, 1'b0, 64'd0);
    chk("mis_err", 64'(fetch_error), 64'd1);
    chk("mis_valid", 64'(if_id_valid), 64'd0);
    chk("mis_addr", Inst_Address, 64'h14);
    for (int k = 0; k < 2; k++) begin
      idle();
      chk("err_sticky", 64'(fetch_error), 64'd1);
      chk("err_addr", Inst_Address, 64'h14);
      chk("err_count", 64'(fetch_count), 64'(exp_count));
    end

    // Asynchronous reset clears ERROR without a clock edge.
    #2 reset = 1'b0;
    exp_count = 32'd0;
    #1 chk_reset_state("arst1");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Restart and run to pc = 0x40, then reset mid-stream.
    for (longint unsigned p = 0; p < 64'h40; p += 4) run(p);
    chk("pre_arst_addr", Inst_Address, 64'h40);
    #2 reset = 1'b0;
    exp_count = 32'd0;
    #1 chk_reset_state("arst2");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("restart_addr", Inst_Address, 64'd0);
    run(64'd0);
    chk("restart_next_addr", Inst_Address, 64'd4);

    // Boundary: 204 is legal, 208 is not.
    issue(1'b0, 1'b0, 1'b1, 64'hCC, 1'b0, 64'd0);
    chk("edge_legal_addr", Inst_Address, 64'hCC);
    chk("edge_legal_err", 64'(fetch_error), 64'd0);
    issue(1'b0, 1'b0, 1'b1, 64'hD0, 1'b0, 64'd0);
    chk("range_err", 64'(fetch_error), 64'd1);
    chk("range_valid", 64'(if_id_valid), 64'd0);
    chk("range_addr", Inst_Address, 64'hCC);
    idle();
    chk("range_err_sticky", 64'(fetch_error), 64'd1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
